// File: rtl/updown_load_counter_if.sv
// updown_load_counter_if: control/status bundle between a counter client and the counter
interface updown_load_counter_if #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 4
);
  logic                 en;
  logic                 load;
  logic [WIDTH-1:0]     load_val;
  logic                 dir;
  logic                 mode;
  logic [WIDTH-1:0]     max_val;
  logic [DIV_WIDTH-1:0] div;
  logic [WIDTH-1:0]     count;
  logic                 tc;
  logic                 at_max;
  logic                 at_zero;
  modport master (
    output en, load, load_val, dir, mode, max_val, div,
    input  count, tc, at_max, at_zero
  );
  modport slave (
    input  en, load, load_val, dir, mode, max_val, div,
    output count, tc, at_max, at_zero
  );
endinterface

// File: rtl/updown_load_counter.sv
// updown_load_counter: prescaled up/down counter with load, terminal value, wrap/saturate and tc pulse
module updown_load_counter #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 4
) (
  input logic clk,
  input logic rst,
  updown_load_counter_if.slave bus
);
  logic [WIDTH-1:0]     count;
  logic [DIV_WIDTH-1:0] pre;
  logic                 tc;
  logic                 tick;
  logic                 lim;
  logic [WIDTH-1:0]     dec;
  logic [WIDTH-1:0]     nxt;
  assign tick = bus.en && (pre >= bus.div);
  assign lim  = bus.dir ? (count >= bus.max_val) : (count == '0);
  assign dec  = count - 1'b1;
  // down-steps from an over-range loaded value snap onto max_val
  always_comb begin
    nxt = bus.dir ? (lim ? (bus.mode ? bus.max_val : '0) : count + 1'b1)
                  : (lim ? (bus.mode ? '0 : bus.max_val)
                         : (dec > bus.max_val ? bus.max_val : dec));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      pre   <= '0;
      tc    <= 1'b0;
    end else if (bus.load) begin
      count <= bus.load_val;
      pre   <= '0;
      tc    <= 1'b0;
    end else begin
      tc <= tick && lim;
      if (bus.en) pre <= tick ? '0 : pre + 1'b1;
      if (tick) count <= nxt;
    end
  end
  assign bus.count   = count;
  assign bus.tc      = tc;
  assign bus.at_max  = count >= bus.max_val;
  assign bus.at_zero = count == '0;
endmodule

// File: tb/tb_updown_load_counter.sv
// tb_updown_load_counter: directed vectors with hand-computed expectations
module tb_updown_load_counter;
  logic clk = 1'b0;
  logic rst;
  int   n_run = 0;
  int   n_fail = 0;
  updown_load_counter_if #(.WIDTH(8), .DIV_WIDTH(4)) bus ();
  updown_load_counter #(.WIDTH(8), .DIV_WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_load(input logic [7:0] v);
    bus.load = 1'b1;
    bus.load_val = v;
    step();
    bus.load = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.dir = 1'b1;
    bus.mode = 1'b0; bus.max_val = 8'd9; bus.div = '0;
    step();
    rst = 1'b0;
    check("rst_count", bus.count, 0);
    check("rst_tc", bus.tc, 0);
    check("rst_at_zero", bus.at_zero, 1);
    // up-wrap 0..9,0
    bus.en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("wrap_count", bus.count, i % 10);
      check("wrap_tc", bus.tc, i == 10);
      check("wrap_at_max", bus.at_max, i == 9);
    end
    // prescaler div=3
    bus.en = 1'b0; bus.max_val = 8'd100; bus.div = 4'd3;
    do_load(8'd0);
    bus.en = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      check("pre_count", bus.count, e / 4);
    end
    bus.en = 1'b0;
    step(); step();
    check("pre_hold", bus.count, 3);
    bus.en = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      check("pre_resume", bus.count, e == 4 ? 4 : 3);
    end
    // down-saturate from 2
    bus.div = '0; bus.max_val = 8'd9;
    do_load(8'd2);
    check("dsat_load", bus.count, 2);
    bus.dir = 1'b0; bus.mode = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("dsat_count", bus.count, i >= 2 ? 0 : 2 - i);
      check("dsat_tc", bus.tc, i >= 3);
      check("dsat_at_zero", bus.at_zero, i >= 2);
    end
    // down-wrap with over-range load
    bus.mode = 1'b0; bus.max_val = 8'd50;
    do_load(8'd200);
    check("ovr_load", bus.count, 200);
    check("ovr_at_max", bus.at_max, 1);
    step();
    check("ovr_snap", bus.count, 50);
    check("ovr_snap_tc", bus.tc, 0);
    step();
    check("ovr_dec", bus.count, 49);
    do_load(8'd0);
    check("dwrap_load", bus.count, 0);
    step();
    check("dwrap_count", bus.count, 50);
    check("dwrap_tc", bus.tc, 1);
    // load beats a due tick and restarts the prescaler
    bus.dir = 1'b1; bus.max_val = 8'd100; bus.div = 4'd3;
    do_load(8'd10);
    step(); step(); step();
    check("sim_pre_wait", bus.count, 10);
    do_load(8'd77);
    check("sim_load", bus.count, 77);
    step(); step(); step();
    check("sim_no_step", bus.count, 77);
    step();
    check("sim_step", bus.count, 78);
    // reset beats load
    rst = 1'b1; bus.load = 1'b1; bus.load_val = 8'd33;
    step();
    rst = 1'b0; bus.load = 1'b0;
    check("rst_load_count", bus.count, 0);
    check("rst_load_tc", bus.tc, 0);
    // up-saturate at 255
    bus.div = '0; bus.mode = 1'b1; bus.max_val = 8'd255;
    do_load(8'd253);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("usat_count", bus.count, i == 1 ? 254 : 255);
      check("usat_tc", bus.tc, i >= 3);
    end
    check("usat_at_max", bus.at_max, 1);
    // max_val=0 keeps count at 0 and pulses tc both ways
    bus.mode = 1'b0; bus.max_val = 8'd0;
    do_load(8'd0);
    step();
    check("max0_up_count", bus.count, 0);
    check("max0_up_tc", bus.tc, 1);
    bus.dir = 1'b0;
    step();
    check("max0_dn_count", bus.count, 0);
    check("max0_dn_tc", bus.tc, 1);
    bus.en = 1'b0;
    step();
    check("idle_tc", bus.tc, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/updown_load_counter.md
# updown_load_counter

Parametrised successor to the team's basic loadable counter. It is an up/down counter with:
- parallel load;
- a programmable terminal value;
- wrap or saturate mode;
- a clock-enable prescaler;
- registered terminal-count pulse and status flags.

It sits in the display/timer path as the general-purpose event counter driving downstream comparators and displays.

## Interface
- WIDTH, 8, counter width in bits (≥ 2)
- DIV_WIDTH, 4, prescaler divisor width in bits (≥ 1)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable; prescaler advances only when high
- load  in  1  parallel load strobe
- load_val  in  WIDTH  value written on load
- dir  in  1  1 = count up, 0 = count down
- mode  in  1  0 = wrap, 1 = saturate
- max_val  in  WIDTH  terminal value; legal range 0..max_val
- div  in  DIV_WIDTH  step every div+1 enabled cycles
- count  out  WIDTH  current count (register)
- tc  out  1  one-cycle terminal-count pulse (register)
- at_max  out  1  count ≥ max_val (combinational from count)
- at_zero  out  1  count == 0 (combinational from count)

## Operation
- Registers:
  - count, WIDTH bits;
  - pre, DIV_WIDTH-bit prescaler;
  - tc.
- Priority each edge is rst > load > step > hold.
- Reset: count=0, pre=0, tc=0.
- Load:
  - count ← load_val and pre ← 0; tc ← 0.
  - Load works regardless of en.
  - load_val > max_val is accepted unchanged.
- Prescaler:
  - With en=1 and no load, tick = (pre ≥ div).
  - On tick, pre ← 0; otherwise pre ← pre+1.
  - With en=0, pre holds.
  - div=0 gives a tick every enabled cycle.
  - A reduction of div below pre mid-run ticks on the next enabled cycle.
- Step (tick=1):
  - Up, count < max_val: count ← count+1.
  - Up, count ≥ max_val:
    - wrap mode: count ← 0;
    - saturate mode: count ← max_val (clamps any over-range loaded value).
    - tc ← 1 in both modes.
  - Down, count ≠ 0: count ← count−1.
    - If the result exceeds max_val (over-range load), count ← max_val instead.
  - Down, count == 0:
    - wrap mode: count ← max_val;
    - saturate mode: count holds 0.
    - tc ← 1 in both modes.
- tc is 0 on every edge that is not a limit step.
  - tc is therefore never high for two consecutive cycles unless consecutive limit steps occur (div=0, saturate mode at the limit).
- max_val=0:
  - Up steps keep count at 0 and pulse tc.
  - Down steps keep count at 0 and pulse tc.
- All arithmetic is modulo 2^WIDTH. The limit checks above guarantee that no natural overflow is ever exposed.
- dir, mode, max_val and div are sampled every edge. Changing them mid-run takes effect on the next edge with no glitch in count.

## Timing
- Step latency: count changes on the first rising edge where tick=1. With en held high from pre=0, that is edge div+1.
- Load latency: 1 edge. count==load_val in the cycle after load is sampled high.
- tc is high for exactly the cycle following the limit-step edge, aligned with the new count value.
- at_max and at_zero have zero latency relative to count.
- Reset mid-count clears count, pre and tc on that edge, overriding a simultaneous load and en.
- load with en=1 on the same edge: the load wins, no step occurs, and the prescaler restarts from 0.

## Test plan
- Reset and up-wrap: WIDTH=8, rst 1 cycle, en=1, dir=1, mode=0, div=0, max_val=9.
  - count goes 0,1,…,9,0.
  - tc is high only in the cycle count returns to 0.
  - at_max is high while count=9.
- Prescaler: div=3, en=1 from pre=0, dir=1.
  - count increments on edges 4, 8, 12.
  - Dropping en for 2 cycles delays the next increment by exactly 2 edges.
- Down-saturate: load_val=2 with load=1, then dir=0, mode=1, en=1, div=0.
  - count goes 2,1,0,0,0.
  - tc pulses on each edge attempted at 0.
  - at_zero stays high from the third cycle.
- Down-wrap and over-range load:
  - load_val=200, max_val=50, dir=0, mode=0 → count goes 200, then 50, 49.
  - Then load_val=0 → the next step gives count=50 with tc=1.
- Simultaneous events:
  - load=1 with en=1, tick due → count=load_val, pre=0, no step.
  - rst=1 with load=1 → count=0, tc=0.
- Up-saturate with max_val=255: count reaches 255 and holds; tc pulses on each further enabled step; no wrap to 0.
